// File: rtl/delayctl_pkg.sv
// Shared types and constants for the delay-line latency controller.
// Included by delay_latency_ctrl; the optional apply counter is enabled by DELAYCTL_STATUS_EN.
package delayctl_pkg;

  localparam int LATENCY_W   = 5;
  localparam int FLUSH_BASE  = 33;
  localparam int FLUSH_CNT_W = 7;
  localparam int DIV_CNT_W   = 4;
  localparam int APPLY_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_FLUSH     = 2'd2
  } state_e;

  // Enables needed to wrap the write index through 31 and refill L+1 entries.
  function automatic logic [FLUSH_CNT_W-1:0] flush_len(input logic [LATENCY_W-1:0] lat);
    return FLUSH_CNT_W'(FLUSH_BASE) + FLUSH_CNT_W'(lat);
  endfunction

endpackage

// File: rtl/delay_latency_ctrl.sv
// Latency change controller for a clock-enabled video delay line: applies new latencies on a line
// boundary and flushes before flagging output valid. Define DELAYCTL_STATUS_EN to add apply_count.
module delay_latency_ctrl
  import delayctl_pkg::*;
#(
  parameter int CE_DIV          = 1,
  parameter int DEFAULT_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [LATENCY_W-1:0] req_latency,
  output logic                 req_ready,
  input  logic                 line_start,
  output logic                 fifo_enable,
  output logic [LATENCY_W-1:0] fifo_latency,
  output logic                 out_valid,
  output logic                 busy
`ifdef DELAYCTL_STATUS_EN
  ,
  output logic [APPLY_CNT_W-1:0] apply_count
`endif
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CE_DIV - 1);
  localparam logic [LATENCY_W-1:0] DEF_LAT  = LATENCY_W'(DEFAULT_LATENCY);

  logic [DIV_CNT_W-1:0]   r_div_cnt;
  state_e                 r_state;
  logic [LATENCY_W-1:0]   r_fifo_latency;
  logic [LATENCY_W-1:0]   r_pending;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic                   r_out_valid;

  logic w_ce;
  logic w_ready;
  logic w_handshake;
  logic w_apply;

  // Handshake: a request is taken on any edge where req_valid and req_ready are both high;
  // the requester holds req_valid and req_latency stable until then.
  assign w_ready     = (r_state == ST_IDLE);
  assign w_handshake = req_valid && w_ready;
  assign w_apply     = (r_state == ST_WAIT_LINE) && line_start;

  // Enable is forced low during reset even when CE_DIV=1 would otherwise hold it high.
  assign w_ce = !reset && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_FLUSH;
      r_fifo_latency <= DEF_LAT;
      r_pending      <= DEF_LAT;
      r_flush_cnt    <= flush_len(DEF_LAT);
      r_out_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_pending <= req_latency;
            if (req_latency != r_fifo_latency) begin
              r_state <= ST_WAIT_LINE;
            end
          end
        end
        ST_WAIT_LINE: begin
          if (w_apply) begin
            r_fifo_latency <= r_pending;
            r_flush_cnt    <= flush_len(r_pending);
            r_out_valid    <= 1'b0;
            r_state        <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_ce) begin
            r_flush_cnt <= r_flush_cnt - FLUSH_CNT_W'(1);
            if (r_flush_cnt == FLUSH_CNT_W'(1)) begin
              r_out_valid <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          // Unreachable encoding: re-flush at the current latency to regain a known state.
          r_flush_cnt <= flush_len(r_fifo_latency);
          r_out_valid <= 1'b0;
          r_state     <= ST_FLUSH;
        end
      endcase
    end
  end

`ifdef DELAYCTL_STATUS_EN
  logic [APPLY_CNT_W-1:0] r_apply_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_apply_count <= '0;
    end else if (w_apply) begin
      r_apply_count <= r_apply_count + APPLY_CNT_W'(1);
    end
  end

  assign apply_count = r_apply_count;
`endif

  assign req_ready    = w_ready;
  assign fifo_enable  = w_ce;
  assign fifo_latency = r_fifo_latency;
  assign out_valid    = r_out_valid;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: doc/delay_latency_ctrl.md
DELAY_LATENCY_CTRL -- requirements
Module: delay_latency_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CE_DIV, 1, clock-enable divide ratio, legal range 1..16.
- DEFAULT_LATENCY, 0, latency applied after reset, legal range 0..31.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, synchronous active-high reset.
- req_valid, in, 1, latency change request.
- req_latency, in, 5, requested latency.
- req_ready, out, 1, request accepted this cycle if req_valid is also high.
- line_start, in, 1, one-cycle video line boundary pulse.
- fifo_enable, out, 1, clock enable to the delay line.
- fifo_latency, out, 5, latency driven to the delay line.
- out_valid, out, 1, delay line output is trustworthy.
- busy, out, 1, high when state is not IDLE.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high, on ports clk and reset.

Function
REQ-004 A divider counter SHALL run 0..CE_DIV-1 and wrap; fifo_enable SHALL be high exactly when counter == CE_DIV-1, so it is constantly high for CE_DIV=1.
REQ-005 The FSM SHALL have three states: IDLE, WAIT_LINE and FLUSH.
REQ-006 req_ready SHALL be high only in IDLE; a handshake occurs when req_valid and req_ready are both high on a clock edge.
REQ-007 On a handshake in IDLE:
- req_latency SHALL be captured into pending.
- If pending equals fifo_latency, the FSM SHALL stay in IDLE, with no flush and no change to out_valid.
- Otherwise the FSM SHALL go to WAIT_LINE.
REQ-008 In WAIT_LINE, a line_start SHALL cause, at the same edge:
- fifo_latency <= pending.
- flush_cnt (7 bit) <= 33 + pending.
- out_valid <= 0.
- state <= FLUSH.
REQ-009 A line_start coinciding with the accepting handshake SHALL be ignored; only line_start pulses sampled in WAIT_LINE count.
REQ-010 In FLUSH, flush_cnt SHALL decrement on each cycle with fifo_enable high. On the decrement 1->0, the FSM SHALL set out_valid <= 1 and go to IDLE at the same edge.
REQ-011 The flush length 33+L SHALL cover the worst case: index wrap-around through 31 (32 enables) plus a refill of L+1 entries.
REQ-012 line_start pulses in IDLE and FLUSH SHALL be ignored.
REQ-013 req_valid held while busy SHALL be neither lost nor accepted until IDLE; the requester keeps req_latency stable.
REQ-014 busy SHALL be a combinational decode of state != IDLE.

Reset
REQ-015 While reset is high:
- divider counter = 0 and fifo_enable = 0.
- fifo_latency = DEFAULT_LATENCY.
- out_valid = 0.
- pending = DEFAULT_LATENCY.
- state = FLUSH.
- flush_cnt = 33 + DEFAULT_LATENCY.
REQ-016 Reset asserted in any state, including mid-FLUSH or WAIT_LINE, SHALL abandon the pending request and restart the reset flush.

Configuration
REQ-017 With DELAYCTL_STATUS_EN defined, an output port apply_count (8 bit) SHALL exist. It SHALL reset to 0, increment at each WAIT_LINE->FLUSH transition, and wrap 255->0.
REQ-018 Without DELAYCTL_STATUS_EN, the apply_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-019 Package delayctl_pkg SHALL hold:
- The state enum typedef.
- LATENCY_W = 5.
- FLUSH_BASE = 33.
- FLUSH_CNT_W = 7.
REQ-020 No sub-module SHALL be instantiated. The parent instantiates the delay line and connects fifo_enable and fifo_latency.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- CE_DIV=1, DEFAULT_LATENCY=0, reset released -> busy=1, then out_valid rises after exactly 33 enables; req_ready=1 thereafter.
- Request latency 10, then line_start 5 cycles later -> fifo_latency=10 at that edge, out_valid low for 43 cycles, apply_count=1.
- Request latency equal to the current fifo_latency -> accepted in 1 cycle, busy never rises, out_valid stays 1.
- CE_DIV=4, request latency 0 -> fifo_enable every 4th cycle, FLUSH lasts 33 enables (132 cycles).
- Reset mid-FLUSH, and line_start coinciding with the handshake -> reset flush restarts; the coincident pulse is ignored and the next pulse applies.
- DELAYCTL_STATUS_EN, 256 applied changes -> apply_count wraps to 0.
